// File: rtl/fpnew_lane_sequencer.sv
// Serialises one packed FP operation onto a single scalar unit, one lane at a time,
// then reassembles the packed result with the OR of the masked lane statuses.
module fpnew_lane_sequencer #(
  parameter int unsigned FpWidth     = 16,
  parameter int unsigned Width       = 64,
  parameter int unsigned NumOperands = 3,
  parameter type         TagType     = logic
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumOperands*Width-1:0]   operands_i,
  input  logic                           vectorial_op_i,
  input  logic [Width/FpWidth-1:0]       simd_mask_i,
  input  TagType                         tag_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic                           flush_i,
  output logic [NumOperands*FpWidth-1:0] unit_operands_o,
  output logic                           unit_valid_o,
  input  logic                           unit_ready_i,
  output logic                           unit_flush_o,
  input  logic [FpWidth-1:0]             unit_result_i,
  input  logic [4:0]                     unit_status_i,
  input  logic                           unit_ext_bit_i,
  input  logic                           unit_valid_i,
  output logic                           unit_ready_o,
  output logic [Width-1:0]               result_o,
  output logic [4:0]                     status_o,
  output logic                           extension_bit_o,
  output TagType                         tag_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           busy_o
);

  localparam int unsigned NUM_LANES = Width / FpWidth;
  localparam int unsigned LaneW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                               state_q, state_d;
  logic [LaneW-1:0]                     lane_cnt_q, lane_cnt_d;
  logic [LaneW-1:0]                     last_q, last_d;
  logic                                 vec_q, vec_d;
  logic [NUM_LANES-1:0]                 mask_q, mask_d;
  TagType                               tag_q, tag_d;
  logic [NumOperands*Width-1:0]         operands_q, operands_d;
  logic [NUM_LANES-1:0][FpWidth-1:0]    slots_q, slots_d;
  logic [4:0]                           status_q, status_d;
  logic                                 ext_q, ext_d;

  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    last_d       = last_q;
    vec_d        = vec_q;
    mask_d       = mask_q;
    tag_d        = tag_q;
    operands_d   = operands_q;
    slots_d      = slots_q;
    status_d     = status_q;
    ext_d        = ext_q;
    in_ready_o   = (state_q == IDLE);
    unit_valid_o = 1'b0;
    unit_ready_o = 1'b0;
    out_valid_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          operands_d = operands_i;
          mask_d     = simd_mask_i;
          tag_d      = tag_i;
          vec_d      = vectorial_op_i;
          lane_cnt_d = '0;
          last_d     = vectorial_op_i ? LaneW'(NUM_LANES - 1) : '0;
          status_d   = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid_o = 1'b1;
        if (unit_ready_i) state_d = WAIT;
      end
      WAIT: begin
        unit_ready_o = 1'b1;
        if (unit_valid_i) begin
          slots_d[lane_cnt_q] = unit_result_i;
          status_d = status_q | (unit_status_i & {5{mask_q[lane_cnt_q]}});
          if (lane_cnt_q == '0) ext_d = unit_ext_bit_i;
          if (lane_cnt_q == last_q) begin
            state_d = DONE;
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides every handshake taken above in the same cycle.
    if (flush_i) begin
      state_d    = IDLE;
      lane_cnt_d = '0;
      status_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      last_q     <= '0;
      vec_q      <= 1'b0;
      mask_q     <= '0;
      tag_q      <= '0;
      operands_q <= '0;
      slots_q    <= '0;
      status_q   <= '0;
      ext_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      last_q     <= last_d;
      vec_q      <= vec_d;
      mask_q     <= mask_d;
      tag_q      <= tag_d;
      operands_q <= operands_d;
      slots_q    <= slots_d;
      status_q   <= status_d;
      ext_q      <= ext_d;
    end
  end

  always_comb begin
    unit_operands_o = '0;
    for (int o = 0; o < NumOperands; o++) begin
      unit_operands_o[o*FpWidth +: FpWidth] =
        operands_q[o*Width + FpWidth*32'(lane_cnt_q) +: FpWidth];
    end
  end

  // Unexecuted lanes and any bits above the lane area carry the lane-0 extension bit.
  always_comb begin
    result_o = {Width{ext_q}};
    for (int l = 0; l < NUM_LANES; l++) begin
      if (vec_q || (l == 0)) result_o[l*FpWidth +: FpWidth] = slots_q[l];
    end
  end

  assign status_o        = status_q;
  assign extension_bit_o = ext_q;
  assign tag_o           = tag_q;
  assign busy_o          = (state_q != IDLE);
  assign unit_flush_o    = flush_i;

endmodule

// File: tb/tb_fpnew_lane_sequencer.sv
// Bench for fpnew_lane_sequencer: a 1-cycle FP16 adder model as the scalar unit and a
// scoreboard of expected packed results checked on each output handshake.
module tb_fpnew_lane_sequencer;

  localparam int FpWidth     = 16;
  localparam int Width       = 64;
  localparam int NumOperands = 3;
  localparam int NumLanes    = Width / FpWidth;

  logic                           clk_i  = 1'b0;
  logic                           rst_ni = 1'b1;
  logic [NumOperands*Width-1:0]   operands_i;
  logic                           vectorial_op_i;
  logic [NumLanes-1:0]            simd_mask_i;
  logic                           tag_i;
  logic                           in_valid_i;
  logic                           in_ready_o;
  logic                           flush_i;
  logic [NumOperands*FpWidth-1:0] unit_operands_o;
  logic                           unit_valid_o;
  logic                           unit_ready_i;
  logic                           unit_flush_o;
  logic [FpWidth-1:0]             unit_result_i;
  logic [4:0]                     unit_status_i;
  logic                           unit_ext_bit_i;
  logic                           unit_valid_i;
  logic                           unit_ready_o;
  logic [Width-1:0]               result_o;
  logic [4:0]                     status_o;
  logic                           extension_bit_o;
  logic                           tag_o;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic                           busy_o;

  always #5 clk_i = ~clk_i;

  fpnew_lane_sequencer #(
    .FpWidth(FpWidth), .Width(Width), .NumOperands(NumOperands), .TagType(logic)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .operands_i(operands_i), .vectorial_op_i(vectorial_op_i),
    .simd_mask_i(simd_mask_i), .tag_i(tag_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .flush_i(flush_i), .unit_operands_o(unit_operands_o), .unit_valid_o(unit_valid_o),
    .unit_ready_i(unit_ready_i), .unit_flush_o(unit_flush_o), .unit_result_i(unit_result_i),
    .unit_status_i(unit_status_i), .unit_ext_bit_i(unit_ext_bit_i), .unit_valid_i(unit_valid_i),
    .unit_ready_o(unit_ready_o), .result_o(result_o), .status_o(status_o),
    .extension_bit_o(extension_bit_o), .tag_o(tag_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic isNan(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 10'h0);
  endfunction

  function automatic logic [4:0] laneStatus(input logic [15:0] a, input logic [15:0] b);
    logic sa, sb;
    sa = isNan(a) && !a[9];
    sb = isNan(b) && !b[9];
    return (sa || sb) ? 5'b10000 : 5'b00000;
  endfunction

  // Non-negative normals/zeros only, truncating; enough for the values used here.
  function automatic logic [15:0] fp16Add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  ea, eb, et;
    logic [11:0] ma, mb, mt, sum;
    int          sh;
    if (isNan(a) || isNan(b)) return 16'h7E00;
    if (a[14:0] == 15'h0) return b;
    if (b[14:0] == 15'h0) return a;
    ea = a[14:10]; eb = b[14:10];
    ma = {2'b01, a[9:0]}; mb = {2'b01, b[9:0]};
    if (eb > ea) begin
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    sh = int'(ea) - int'(eb);
    mb = (sh > 11) ? 12'h0 : (mb >> sh);
    sum = ma + mb;
    if (sum[11]) begin
      sum = sum >> 1;
      ea  = ea + 5'd1;
    end
    return {1'b0, ea, sum[9:0]};
  endfunction

  // Scalar unit model: result presented the cycle after the issue handshake.
  logic        unitRespValid;
  logic [15:0] unitRespRes;
  logic [4:0]  unitRespStat;
  logic        unitReadyEn;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unitRespValid <= 1'b0;
      unitRespRes   <= 16'h0;
      unitRespStat  <= 5'h0;
    end else if (unit_flush_o) begin
      unitRespValid <= 1'b0;
    end else if (unit_valid_o && unit_ready_i) begin
      unitRespValid <= 1'b1;
      unitRespRes   <= fp16Add(unit_operands_o[15:0], unit_operands_o[31:16]);
      unitRespStat  <= laneStatus(unit_operands_o[15:0], unit_operands_o[31:16]);
    end else if (unitRespValid && unit_ready_o) begin
      unitRespValid <= 1'b0;
    end
  end

  assign unit_valid_i   = unitRespValid;
  assign unit_result_i  = unitRespRes;
  assign unit_status_i  = unitRespStat;
  assign unit_ext_bit_i = 1'b1;
  assign unit_ready_i   = unitReadyEn;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  stat;
    logic        ext;
    logic        tag;
    logic        checkLat;
    int          expCycle;
  } expEntry_t;

  expEntry_t   sbQ[$];
  expEntry_t   monEntry;
  int          cycleCnt = 0;
  int          issueCnt = 0;
  int          issueLane = 0;
  int          firstOutCycle = 0;
  logic        prevOutValid = 1'b0;
  logic [63:0] curOp0, curOp1, curOp2;
  logic [63:0] lastResult;
  logic [4:0]  lastStatus;

  always @(posedge clk_i) begin
    cycleCnt <= cycleCnt + 1;
    if (rst_ni && unit_valid_o && unit_ready_i) issueCnt <= issueCnt + 1;
  end

  // Monitor: checks each lane issue against the op's lanes and pops the scoreboard on output.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (unit_valid_o && unit_ready_i) begin
        checkOutput("unit_ops", {16'h0, unit_operands_o},
                    {16'h0, curOp2[issueLane*16 +: 16], curOp1[issueLane*16 +: 16], curOp0[issueLane*16 +: 16]});
        issueLane++;
      end
      if (out_valid_o && !prevOutValid) firstOutCycle = cycleCnt;
      if (out_valid_o && out_ready_i) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_out", 64'd1, 64'd0);
        end else begin
          monEntry = sbQ.pop_front();
          lastResult = result_o;
          lastStatus = status_o;
          checkOutput("result", result_o, monEntry.res);
          checkOutput("status", {59'h0, status_o}, {59'h0, monEntry.stat});
          checkOutput("ext_bit", {63'h0, extension_bit_o}, {63'h0, monEntry.ext});
          checkOutput("tag", {63'h0, tag_o}, {63'h0, monEntry.tag});
          if (monEntry.checkLat) checkOutput("latency", 64'(firstOutCycle), 64'(monEntry.expCycle));
        end
      end
    end
    prevOutValid = out_valid_o;
  end

  task automatic applyStimulus(input logic [63:0] op0, input logic [63:0] op1, input logic [63:0] op2,
                               input logic vec, input logic [3:0] mask, input logic opTag,
                               input logic expectOut, input logic checkLat);
    expEntry_t e;
    int        lanes;
    logic      accepted;
    e.res  = {64{1'b1}};
    e.stat = 5'h0;
    e.ext  = 1'b1;
    e.tag  = opTag;
    e.checkLat = checkLat;
    lanes = vec ? NumLanes : 1;
    for (int l = 0; l < lanes; l++) begin
      e.res[l*16 +: 16] = fp16Add(op0[l*16 +: 16], op1[l*16 +: 16]);
      if (mask[l]) e.stat = e.stat | laneStatus(op0[l*16 +: 16], op1[l*16 +: 16]);
    end
    @(posedge clk_i); #1;
    operands_i     = {op2, op1, op0};
    vectorial_op_i = vec;
    simd_mask_i    = mask;
    tag_i          = opTag;
    in_valid_i     = 1'b1;
    accepted       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready_o) begin
        accepted   = 1'b1;
        e.expCycle = cycleCnt + 2*lanes + 1;
        curOp0 = op0; curOp1 = op1; curOp2 = op2;
        issueLane = 0;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (accepted) begin
      if (expectOut) sbQ.push_back(e);
      @(posedge clk_i); #1;
    end else begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic waitIdle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i); #1;
      if (sbQ.size() == 0 && !busy_o) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          base;
    logic        seen;
    operands_i = '0; vectorial_op_i = 1'b0; simd_mask_i = '0; tag_i = 1'b0;
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1; unitReadyEn = 1'b1;

    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_in_ready", {63'h0, in_ready_o}, 64'd1);
    checkOutput("rst_unit_valid", {63'h0, unit_valid_o}, 64'd0);
    checkOutput("rst_unit_ready", {63'h0, unit_ready_o}, 64'd0);
    checkOutput("rst_out_valid", {63'h0, out_valid_o}, 64'd0);
    checkOutput("rst_busy", {63'h0, busy_o}, 64'd0);
    checkOutput("rst_result", result_o, 64'd0);
    checkOutput("rst_status", {59'h0, status_o}, 64'd0);
    rst_ni = 1'b1;

    $display("[TB] scalar add");
    applyStimulus(64'h1234_5678_0ABC_3C00, 64'h1111_2222_3333_4000, 64'h5555_6666_7777_8888, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1);
    waitIdle();
    checkOutput("scalar_const", lastResult, 64'hFFFF_FFFF_FFFF_4200);

    $display("[TB] vector add");
    base = issueCnt;
    applyStimulus(64'h3C00_3C00_3C00_3C00, 64'h4000_3C00_0000_3C00, 64'h0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1);
    waitIdle();
    checkOutput("vector_const", lastResult, 64'h4200_4000_3C00_4000);
    checkOutput("vector_issues", 64'(issueCnt - base), 64'd4);

    $display("[TB] status mask");
    applyStimulus(64'h3C00_3C00_3C00_3C00, 64'h3C00_7D00_3C00_3C00, 64'h0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1);
    waitIdle();
    checkOutput("mask_off_status", {59'h0, lastStatus}, 64'd0);
    applyStimulus(64'h3C00_3C00_3C00_3C00, 64'h3C00_7D00_3C00_3C00, 64'h0, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b1);
    waitIdle();
    checkOutput("mask_on_status", {59'h0, lastStatus}, 64'h10);

    $display("[TB] backpressure");
    base = issueCnt;
    unitReadyEn = 1'b0;
    applyStimulus(64'h4000_4000_4000_4000, 64'h3C00_4000_0000_4000, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_unit_valid", {63'h0, unit_valid_o}, 64'd1);
      checkOutput("bp_unit_ops", {16'h0, unit_operands_o}, 64'h0000_DDDD_4000_4000);
      checkOutput("bp_in_ready", {63'h0, in_ready_o}, 64'd0);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b0;
    unitReadyEn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    checkOutput("bp_out_seen", {63'h0, seen}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", {63'h0, out_valid_o}, 64'd1);
      checkOutput("bp_result_hold", result_o, 64'h4200_4400_4000_4400);
      checkOutput("bp_in_ready_out", {63'h0, in_ready_o}, 64'd0);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    waitIdle();
    checkOutput("bp_issues", 64'(issueCnt - base), 64'd4);

    $display("[TB] flush in lane 1 wait");
    base = issueCnt;
    applyStimulus(64'h3C00_3C00_3C00_7D00, 64'h3C00_3C00_3C00_3C00, 64'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (issueCnt == base + 2 && unit_ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("flush_reach_wait", {63'h0, seen}, 64'd1);
    flush_i = 1'b1;
    checkOutput("unit_flush", {63'h0, unit_flush_o}, 64'd1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    checkOutput("flush_busy", {63'h0, busy_o}, 64'd0);
    checkOutput("flush_in_ready", {63'h0, in_ready_o}, 64'd1);
    checkOutput("flush_status", {59'h0, status_o}, 64'd0);
    repeat (3) begin
      checkOutput("flush_no_out", {63'h0, out_valid_o}, 64'd0);
      @(posedge clk_i); #1;
    end
    applyStimulus(64'h3C00_3C00_3C00_3C00, 64'h4000_7D00_3C00_0000, 64'h0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1);
    waitIdle();

    $display("[TB] async reset mid-issue");
    unitReadyEn = 1'b0;
    applyStimulus(64'h3C00_3C00_3C00_3C00, 64'h3C00_3C00_3C00_3C00, 64'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_issue", {63'h0, unit_valid_o}, 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("arst_unit_valid", {63'h0, unit_valid_o}, 64'd0);
    checkOutput("arst_out_valid", {63'h0, out_valid_o}, 64'd0);
    checkOutput("arst_busy", {63'h0, busy_o}, 64'd0);
    checkOutput("arst_in_ready", {63'h0, in_ready_o}, 64'd1);
    checkOutput("arst_result", result_o, 64'd0);
    checkOutput("arst_status", {59'h0, status_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    unitReadyEn = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("post_rst_in_ready", {63'h0, in_ready_o}, 64'd1);
    applyStimulus(64'h0000_0000_0000_4000, 64'h0000_0000_0000_3C00, 64'h0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1);
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
